// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the RV32I/RV64I immediate
// of each fetched word and hands it to decode through a 2-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN       = 32,
  parameter bit EN_ZIMM    = 1'b1,
  parameter bit SHAMT_MODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t dec;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_shift;
  logic       accept;
  logic       pop;

  assign opc      = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign is_shift = SHAMT_MODE && (f3 == 3'b001 || f3 == 3'b101);

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_inst = head_q.inst;
  assign out_imm  = head_q.imm;
  assign out_fmt  = head_q.fmt;

  // Decode format and extended immediate of the incoming word.
  always_comb begin
    dec      = '0;
    dec.inst = in_inst;
    case (opc)
      OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_inst[31:20]));
      end
      OP_IMM: begin
        dec.fmt = FMT_I;
        if (is_shift) begin
          if (XLEN == 64)
            dec.imm = XLEN'(in_inst[25:20]);
          else
            dec.imm = XLEN'(in_inst[24:20]);
        end else begin
          dec.imm = XLEN'($signed(in_inst[31:20]));
        end
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          if (is_shift)
            dec.imm = XLEN'(in_inst[24:20]);
          else
            dec.imm = XLEN'($signed(in_inst[31:20]));
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_inst[31:25],
                                 in_inst[11:7]}));
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_inst[31],
                                 in_inst[7],
                                 in_inst[30:25],
                                 in_inst[11:8],
                                 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_inst[31:12],
                                 12'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_inst[31],
                                 in_inst[19:12],
                                 in_inst[20],
                                 in_inst[30:21],
                                 1'b0}));
      end
      OP_SYSTEM: begin
        if (EN_ZIMM && f3 != 3'b000) begin
          dec.fmt = FMT_Z;
          dec.imm = XLEN'(in_inst[19:15]);
        end
      end
      default: begin
        dec.fmt = FMT_NONE;
      end
    endcase
  end

  // Skid-buffer next state; flush wins over any accept or pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_d  = dec;
            state_d = ST_FULL;
          end else if (accept && pop) begin
            head_d  = dec;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomised bench for imm_gen_stage: three parameter variants share one
// input stream and are checked every cycle against a queue-based model.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        ov32, ir32;
  logic [31:0] oi32;
  logic [31:0] im32;
  logic [2:0]  of32;

  logic        ova, ira;
  logic [31:0] oia;
  logic [63:0] ima;
  logic [2:0]  ofa;

  logic        ovb, irb;
  logic [31:0] oib;
  logic [63:0] imb;
  logic [2:0]  ofb;

  int errs;
  int checks;

  logic [31:0] q[$];
  logic [31:0] popped[$];
  bit          last_acc;

  imm_gen_stage #(.XLEN(32), .EN_ZIMM(1'b1), .SHAMT_MODE(1'b1)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32), .in_inst(in_inst),
    .out_valid(ov32), .out_ready(out_ready),
    .out_inst(oi32), .out_imm(im32), .out_fmt(of32)
  );

  imm_gen_stage #(.XLEN(64), .EN_ZIMM(1'b0), .SHAMT_MODE(1'b1)) u64a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ira), .in_inst(in_inst),
    .out_valid(ova), .out_ready(out_ready),
    .out_inst(oia), .out_imm(ima), .out_fmt(ofa)
  );

  imm_gen_stage #(.XLEN(64), .EN_ZIMM(1'b1), .SHAMT_MODE(1'b0)) u64b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(irb), .in_inst(in_inst),
    .out_valid(ovb), .out_ready(out_ready),
    .out_inst(oib), .out_imm(imb), .out_fmt(ofb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic longint sx(input longint v, input int b);
    longint half;
    half = longint'(1) << (b - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Immediate decode written straight from the ISA field layouts.
  function automatic void ref_dec(input logic [31:0] w, input int xl,
                                  input bit ez, input bit sm,
                                  output logic [63:0] imm,
                                  output logic [2:0] fmt);
    logic [6:0] opc;
    logic [2:0] f3;
    longint     u;
    bit         sh;
    opc = w[6:0];
    f3  = w[14:12];
    u   = longint'(w);
    sh  = sm && (f3 == 3'd1 || f3 == 3'd5);
    imm = 64'd0;
    fmt = 3'd0;
    if (opc == 7'h03 || opc == 7'h67 || opc == 7'h13 ||
        (opc == 7'h1b && xl == 64)) begin
      fmt = 3'd1;
      imm = sx(u >> 20, 12);
      if (sh && opc == 7'h13) imm = (u >> 20) % (xl == 64 ? 64 : 32);
      if (sh && opc == 7'h1b) imm = (u >> 20) % 32;
    end else if (opc == 7'h23) begin
      fmt = 3'd2;
      imm = sx(((u >> 25) << 5) + ((u >> 7) % 32), 12);
    end else if (opc == 7'h63) begin
      fmt = 3'd3;
      imm = sx(((u >> 31) << 12) + (((u >> 7) % 2) << 11) +
               (((u >> 25) % 64) << 5) + (((u >> 8) % 16) << 1), 13);
    end else if (opc == 7'h37 || opc == 7'h17) begin
      fmt = 3'd4;
      imm = sx((u >> 12) << 12, 32);
    end else if (opc == 7'h6f) begin
      fmt = 3'd5;
      imm = sx(((u >> 31) << 20) + (((u >> 12) % 256) << 12) +
               (((u >> 20) % 2) << 11) + (((u >> 21) % 1024) << 1), 21);
    end else if (opc == 7'h73 && f3 != 3'd0 && ez) begin
      fmt = 3'd6;
      imm = (u >> 15) % 32;
    end
    if (xl == 32) imm[63:32] = 32'd0;
  endfunction

  // Transaction model: a FIFO of at most two instruction words.
  always @(posedge clk or posedge rst) begin
    bit acc, pp;
    if (rst) begin
      q.delete();
      last_acc = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      last_acc = acc && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(in_inst);
      end
    end
  end

  task automatic cmp(input string nm, input int xl, input bit ez,
                     input bit sm, input logic ov, input logic ir,
                     input logic [31:0] oi, input logic [63:0] im,
                     input logic [2:0] fm);
    logic [63:0] ei;
    logic [2:0]  ef;
    chk({nm, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
    chk({nm, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
    if (q.size() > 0) begin
      ref_dec(q[0], xl, ez, sm, ei, ef);
      chk({nm, ".out_inst"}, 64'(oi), 64'(q[0]));
      chk({nm, ".out_imm"}, im, ei);
      chk({nm, ".out_fmt"}, 64'(fm), 64'(ef));
    end
  endtask

  // Per-cycle comparison of every variant against the model.
  always @(negedge clk) begin
    cmp("x32", 32, 1'b1, 1'b1, ov32, ir32, oi32, {32'd0, im32}, of32);
    cmp("x64nz", 64, 1'b0, 1'b1, ova, ira, oia, ima, ofa);
    cmp("x64ns", 64, 1'b1, 1'b0, ovb, irb, oib, imb, ofb);
    if (ov32 && out_ready) popped.push_back(oi32);
  end

  task automatic send(input logic [31:0] w);
    bit ok;
    in_valid = 1'b1;
    in_inst  = w;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = last_acc;
    end
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[12];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h1b, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6f, 7'h73, 7'h33, 7'h0f};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ei;
    logic [2:0]  ef;
    logic [31:0] wa, wb, wc;
    errs = 0;
    checks = 0;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = 32'd0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(ov32), 64'd0);
    chk("rst.in_ready", 64'(ir32), 64'd1);
    chk("rst.out_inst", 64'(oi32), 64'd0);
    chk("rst.out_imm", 64'(im32), 64'd0);
    chk("rst.out_fmt", 64'(of32), 64'd0);
    chk("rst.out_imm64", ima, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    ref_dec(32'hFE000EE3, 32, 1'b1, 1'b1, ei, ef);
    chk("model.beq", ei, 64'h0000_0000_FFFF_FFFC);
    ref_dec(32'h800000B7, 64, 1'b1, 1'b1, ei, ef);
    chk("model.lui64", ei, 64'hFFFF_FFFF_8000_0000);
    ref_dec(32'h0000101B, 32, 1'b1, 1'b1, ei, ef);
    chk("model.imm32_on_rv32", 64'(ef), 64'd0);
    ref_dec(32'hFFDFF06F, 64, 1'b1, 1'b1, ei, ef);
    chk("model.jal_back", ei, 64'hFFFF_FFFF_FFFF_FFFC);

    out_ready = 1'b1;
    send(32'hFFF00093);
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi.imm", 64'(im32), 64'hFFFF_FFFF);
    chk("addi.fmt", 64'(of32), 64'd1);
    send(32'hFE000EE3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("beq.imm", 64'(im32), 64'hFFFF_FFFC);
    chk("beq.fmt", 64'(of32), 64'd3);
    send(32'h123450B7);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lui.imm", 64'(im32), 64'h1234_5000);
    chk("lui.fmt", 64'(of32), 64'd4);
    send(32'h800000B7);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lui64.imm", ima, 64'hFFFF_FFFF_8000_0000);
    send(32'h4030D093);
    in_valid = 1'b0;
    @(negedge clk);
    chk("srai64.imm", ima, 64'd3);
    chk("srai64.fmt", 64'(ofa), 64'd1);
    chk("srai_noshamt.imm", imb, 64'h403);
    send(32'h300FD073);
    in_valid = 1'b0;
    @(negedge clk);
    chk("csrrwi.imm", 64'(im32), 64'h1F);
    chk("csrrwi.fmt", 64'(of32), 64'd6);
    chk("csrrwi_nozimm.imm", ima, 64'd0);
    chk("csrrwi_nozimm.fmt", 64'(ofa), 64'd0);

    @(posedge clk);
    #1 out_ready = 1'b0;
    popped.delete();
    wa = 32'h00A00513;
    wb = 32'hFFC10113;
    wc = 32'h008000EF;
    send(wa);
    send(wb);
    in_inst = wc;
    @(negedge clk);
    chk("full.in_ready", 64'(ir32), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full.head_held", 64'(oi32), 64'(wa));
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(wc);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("order.count", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      chk("order.0", 64'(popped[0]), 64'(wa));
      chk("order.1", 64'(popped[1]), 64'(wb));
      chk("order.2", 64'(popped[2]), 64'(wc));
    end

    out_ready = 1'b0;
    send(wa);
    send(wb);
    in_inst = wc;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush.out_valid", 64'(ov32), 64'd0);
    chk("flush.in_ready", 64'(ir32), 64'd1);
    chk("flush.out_inst", 64'(oi32), 64'd0);
    chk("flush.out_imm", 64'(im32), 64'd0);
    chk("flush.out_fmt", 64'(of32), 64'd0);

    send(wa);
    send(wb);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst.out_valid", 64'(ov32), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.out_valid", 64'(ov32), 64'd0);
    chk("async_rst.in_ready", 64'(ir32), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst.out_valid", 64'(ova), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_inst  = rand_inst();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
